// File: rtl/fp16_align_shifter_pkg.sv
// Shared widths, field layout and FSM encoding for the FP16 adder alignment stage.
package fp16_pkg;

   localparam int EXP_W = 5;
   localparam int MAN_W = 10;
   localparam int SIG_W = MAN_W + 4;
   localparam int CNT_W = $clog2(SIG_W + 1);
   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp16_t;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} align_state_e;

   // Aligned significand layout: {hidden, man, guard, round, sticky}
   function automatic logic [SIG_W-1:0] init_sig(input logic hidden, input logic [MAN_W-1:0] man);
      return {hidden, man, 3'b000};
   endfunction

endpackage

// File: rtl/fp16_align_shifter_unpack.sv
// Splits an IEEE-754 half into the fields and class flags the alignment stage needs.
module fp16_unpack
   import fp16_pkg::*;
(
   input  fp16_t            x,
   output logic             sign,
   output logic [EXP_W-1:0] exp,
   output logic [MAN_W-1:0] man,
   output logic             hidden,
   output logic             is_sub,
   output logic             is_special
);

   assign sign       = x.sign;
   assign exp        = x.exp;
   assign man        = x.man;
   assign is_sub     = (x.exp == '0);
   assign hidden     = ~is_sub;
   assign is_special = (x.exp == EXP_MAX);

endmodule

// File: rtl/fp16_align_shifter.sv
// FP16 operand alignment: picks the larger-exponent operand and right-shifts the other
// one bit per clock with guard/round/sticky, then holds the aligned pair for the adder.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SHIFT | shifting small_sig one bit per clock, cnt bits remaining
// DONE  | aligned pair valid, held until out_ready
module fp16_align_shifter
   import fp16_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      a_in,
   input  logic [15:0]      b_in,
   input  logic [EXP_W-1:0] exp_diff,
   input  logic             exp_a_ge_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             big_sign,
   output logic             small_sign,
   output logic [EXP_W-1:0] big_exp,
   output logic [SIG_W-1:0] big_sig,
   output logic [SIG_W-1:0] small_sig,
   output logic             swapped,
   output logic             eff_sub,
   output logic             special
);

   align_state_e     state, state_nxt;
   logic             a_sign, b_sign, a_hid, b_hid, a_sub, b_sub, a_spc, b_spc;
   logic [EXP_W-1:0] a_exp, b_exp, d_raw, d_adj;
   logic [MAN_W-1:0] a_man, b_man;
   logic [CNT_W-1:0] k_in, cnt;
   logic             accept, spc_in;

   fp16_unpack u_unpack_a (
      .x          (fp16_t'(a_in)),
      .sign       (a_sign),
      .exp        (a_exp),
      .man        (a_man),
      .hidden     (a_hid),
      .is_sub     (a_sub),
      .is_special (a_spc)
   );

   fp16_unpack u_unpack_b (
      .x          (fp16_t'(b_in)),
      .sign       (b_sign),
      .exp        (b_exp),
      .man        (b_man),
      .hidden     (b_hid),
      .is_sub     (b_sub),
      .is_special (b_spc)
   );

   assign accept = in_valid & in_ready;
   assign spc_in = a_spc | b_spc;
   assign d_raw  = exp_a_ge_b ? exp_diff : (~exp_diff + EXP_W'(1));
   // A subnormal's effective exponent is 1, not 0, so mixed pairs shift one less
   assign d_adj  = ((a_sub ^ b_sub) && (d_raw != '0)) ? d_raw - EXP_W'(1) : d_raw;
   assign k_in   = spc_in                    ? '0 :
                   (d_adj > EXP_W'(SIG_W))   ? CNT_W'(SIG_W) : CNT_W'(d_adj);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)           state_nxt = (k_in != '0) ? SHIFT : DONE;
         SHIFT:   if (cnt == CNT_W'(1))   state_nxt = DONE;
         DONE:    if (out_ready)          state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         big_sign   <= 1'b0;
         small_sign <= 1'b0;
         big_exp    <= '0;
         big_sig    <= '0;
         small_sig  <= '0;
         swapped    <= 1'b0;
         eff_sub    <= 1'b0;
         special    <= 1'b0;
         cnt        <= '0;
      end else if (accept) begin
         swapped <= ~exp_a_ge_b;
         eff_sub <= a_sign ^ b_sign;
         special <= spc_in;
         cnt     <= k_in;
         if (exp_a_ge_b) begin
            big_sign   <= a_sign;
            small_sign <= b_sign;
            big_exp    <= a_exp;
            big_sig    <= init_sig(a_hid, a_man);
            small_sig  <= init_sig(b_hid, b_man);
         end else begin
            big_sign   <= b_sign;
            small_sign <= a_sign;
            big_exp    <= b_exp;
            big_sig    <= init_sig(b_hid, b_man);
            small_sig  <= init_sig(a_hid, a_man);
         end
      end else if (state == SHIFT) begin
         // bit 1 falls into sticky; sticky stays set once any one-bit passes through
         small_sig <= {1'b0, small_sig[SIG_W-1:2], |small_sig[1:0]};
         cnt       <= cnt - CNT_W'(1);
      end
   end

endmodule
